instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 51 +++++
 rtl/instr_fetch.sv | 125 ++++++++++++
 tb/tb_instr_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: ROM read port, execute handshake, decoded fields.
// master = fetch unit, slave = ROM / execute / PC side.
interface instr_fetch_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] i_Address_Instruction_Bus;
  logic [ADDR_W-1:0] o_rom_addr;
  logic              o_rom_rd;
  logic [15:0]       i_rom_data;
  logic              i_rom_ack;
  logic [15:0]       o_instr;
  logic [3:0]        o_opcode;
  logic [3:0]        o_cond;
  logic [7:0]        o_imm;
  logic              o_valid;
  logic              i_ready;
  logic              o_fetch_done;
  logic              o_err;

  modport master (
    input  i_Address_Instruction_Bus,
    input  i_rom_data,
    input  i_rom_ack,
    input  i_ready,
    output o_rom_addr,
    output o_rom_rd,
    output o_instr,
    output o_opcode,
    output o_cond,
    output o_imm,
    output o_valid,
    output o_fetch_done,
    output o_err
  );

  modport slave (
    output i_Address_Instruction_Bus,
    output i_rom_data,
    output i_rom_ack,
    output i_ready,
    input  o_rom_addr,
    input  o_rom_rd,
    input  o_instr,
    input  o_opcode,
    input  o_cond,
    input  o_imm,
    input  o_valid,
    input  o_fetch_done,
    input  o_err
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE -> WAIT (ROM read) -> HOLD (until consumed).
// Define IFETCH_TIMEOUT_EN to enable the ROM acknowledge watchdog (o_err).
module instr_fetch #(
  parameter int ADDR_W    = 8,
  parameter int TO_CYCLES = 15
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  if (TO_CYCLES < 1 || TO_CYCLES > 15) begin : g_bad_to
    $error("TO_CYCLES must be in 1..15");
  end

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              rd_q, rd_n;
  logic [15:0]       instr_q, instr_n;
  logic              valid_q, valid_n;
  logic              done_q, done_n;

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(TO_CYCLES - 1);

  logic       err_q, err_n;
  logic [3:0] cnt_q, cnt_n;
`endif

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    rd_n    = rd_q;
    instr_n = instr_q;
    valid_n = valid_q;
    done_n  = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
    err_n   = err_q;
    cnt_n   = cnt_q;
`endif
    unique case (state)
      IDLE: begin
        addr_n  = bus.i_Address_Instruction_Bus;
        rd_n    = 1'b1;
        state_n = WAIT;
`ifdef IFETCH_TIMEOUT_EN
        cnt_n   = '0;
`endif
      end
      WAIT: begin
        if (bus.i_rom_ack) begin
          instr_n = bus.i_rom_data;
          valid_n = 1'b1;
          rd_n    = 1'b0;
          state_n = HOLD;
        end
`ifdef IFETCH_TIMEOUT_EN
        // Ack on the timeout edge still wins above.
        else if (cnt_q == TO_LAST) begin
          err_n   = 1'b1;
          rd_n    = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + 4'd1;
        end
`endif
      end
      HOLD: begin
        if (bus.i_ready) begin
          valid_n = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      rd_q    <= rd_n;
      instr_q <= instr_n;
      valid_q <= valid_n;
      done_q  <= done_n;
`ifdef IFETCH_TIMEOUT_EN
      err_q   <= err_n;
      cnt_q   <= cnt_n;
`endif
    end
  end

  assign bus.o_rom_addr   = addr_q;
  assign bus.o_rom_rd     = rd_q;
  assign bus.o_instr      = instr_q;
  assign bus.o_opcode     = instr_q[15:12];
  assign bus.o_cond       = instr_q[11:8];
  assign bus.o_imm        = instr_q[7:0];
  assign bus.o_valid      = valid_q;
  assign bus.o_fetch_done = done_q;
`ifdef IFETCH_TIMEOUT_EN
  assign bus.o_err        = err_q;
`else
  assign bus.o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a queue-based read/instruction scoreboard.
// Covers both IFETCH_TIMEOUT_EN builds.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_if #(.ADDR_W(8)) bus ();

  instr_fetch #(
    .ADDR_W   (8),
    .TO_CYCLES(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0]  addr_q[$];
  logic [15:0] instr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every new ROM read and every new valid instruction
  // is matched against the next expected entry.
  logic prev_rd    = 1'b0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (bus.o_rom_rd === 1'b1 && prev_rd !== 1'b1) begin
      if (addr_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_read: addr 0x%0h, none expected",
                 bus.o_rom_addr);
      end else begin
        check("rom_addr", 32'(bus.o_rom_addr), 32'(addr_q.pop_front()));
      end
    end
    if (bus.o_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (instr_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: instr 0x%0h, none expected",
                 bus.o_instr);
      end else begin
        logic [15:0] e;
        e = instr_q.pop_front();
        check("instr",  32'(bus.o_instr),  32'(e));
        check("opcode", 32'(bus.o_opcode), 32'(e[15:12]));
        check("cond",   32'(bus.o_cond),   32'(e[11:8]));
        check("imm",    32'(bus.o_imm),    32'(e[7:0]));
      end
    end
    prev_rd    <= bus.o_rom_rd;
    prev_valid <= bus.o_valid;
  end

  logic [15:0] d_tab [4];
  logic [7:0]  nxt;
  int          last;

  initial begin
    d_tab = '{16'hA001, 16'hB102, 16'hC203, 16'hD304};
    rst = 1'b1;
    bus.i_Address_Instruction_Bus = 8'h10;
    bus.i_rom_data = 16'h0000;
    bus.i_rom_ack  = 1'b0;
    bus.i_ready    = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_addr",  32'(bus.o_rom_addr),   32'h0);
    check("rst_rd",    32'(bus.o_rom_rd),     32'h0);
    check("rst_instr", 32'(bus.o_instr),      32'h0);
    check("rst_valid", 32'(bus.o_valid),      32'h0);
    check("rst_done",  32'(bus.o_fetch_done), 32'h0);
    check("rst_err",   32'(bus.o_err),        32'h0);

    // First fetch at 0x10, ack one cycle after rd
    addr_q.push_back(8'h10);
    instr_q.push_back(16'h2A35);
    rst = 1'b0;
    @(negedge clk);
    check("first_rd", 32'(bus.o_rom_rd), 32'h1);
    bus.i_rom_ack  = 1'b1;
    bus.i_rom_data = 16'h2A35;
    @(negedge clk);
    bus.i_rom_ack = 1'b0;
    check("f1_instr",  32'(bus.o_instr),  32'h2A35);
    check("f1_opcode", 32'(bus.o_opcode), 32'h2);
    check("f1_cond",   32'(bus.o_cond),   32'hA);
    check("f1_imm",    32'(bus.o_imm),    32'h35);
    check("f1_valid",  32'(bus.o_valid),  32'h1);
    check("f1_rd_off", 32'(bus.o_rom_rd), 32'h0);

    // Hold 5 cycles, address change and stray ack ignored
    bus.i_Address_Instruction_Bus = 8'h44;
    for (int i = 0; i < 5; i++) begin
      bus.i_rom_ack  = (i == 2);
      bus.i_rom_data = 16'hFFFF;
      @(negedge clk);
      check("hold_valid", 32'(bus.o_valid),      32'h1);
      check("hold_instr", 32'(bus.o_instr),      32'h2A35);
      check("hold_done",  32'(bus.o_fetch_done), 32'h0);
    end
    bus.i_rom_ack = 1'b0;
    addr_q.push_back(8'h44);
    instr_q.push_back(16'h1234);
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("consume_done",  32'(bus.o_fetch_done), 32'h1);
    check("consume_valid", 32'(bus.o_valid),      32'h0);
    bus.i_ready = 1'b0;
    @(negedge clk);
    check("done_pulse_end", 32'(bus.o_fetch_done), 32'h0);
    check("f2_rd",          32'(bus.o_rom_rd),     32'h1);

    // ROM ack delayed 7 cycles; address change during WAIT ignored
    bus.i_Address_Instruction_Bus = 8'h99;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("wait_rd",   32'(bus.o_rom_rd),   32'h1);
      check("wait_addr", 32'(bus.o_rom_addr), 32'h44);
      check("wait_err",  32'(bus.o_err),      32'h0);
    end
    bus.i_rom_ack  = 1'b1;
    bus.i_rom_data = 16'h1234;
    @(negedge clk);
    bus.i_rom_ack = 1'b0;
    check("f2_valid", 32'(bus.o_valid), 32'h1);
    check("f2_err",   32'(bus.o_err),   32'h0);
    addr_q.push_back(8'h99);
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("f2_done", 32'(bus.o_fetch_done), 32'h1);
    bus.i_ready = 1'b0;
    @(negedge clk);

    // Reset mid-WAIT with simultaneous ack/ready, then a late ack
    rst = 1'b1;
    bus.i_rom_ack  = 1'b1;
    bus.i_ready    = 1'b1;
    bus.i_rom_data = 16'hBEEF;
    @(negedge clk);
    check("mrst_addr",  32'(bus.o_rom_addr),   32'h0);
    check("mrst_rd",    32'(bus.o_rom_rd),     32'h0);
    check("mrst_instr", 32'(bus.o_instr),      32'h0);
    check("mrst_valid", 32'(bus.o_valid),      32'h0);
    check("mrst_done",  32'(bus.o_fetch_done), 32'h0);
    check("mrst_err",   32'(bus.o_err),        32'h0);
    rst = 1'b0;
    bus.i_rom_data = 16'hCAFE;
    bus.i_ready    = 1'b0;
    bus.i_Address_Instruction_Bus = 8'h00;
    addr_q.push_back(8'h00);
    @(negedge clk);
    check("late_ack_instr", 32'(bus.o_instr),  32'h0);
    check("late_ack_valid", 32'(bus.o_valid),  32'h0);
    check("restart_rd",     32'(bus.o_rom_rd), 32'h1);

    // Back-to-back zero-wait fetches 0x00..0x03
    bus.i_ready = 1'b1;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      bus.i_rom_ack  = 1'b1;
      bus.i_rom_data = d_tab[i];
      instr_q.push_back(d_tab[i]);
      @(negedge clk);
      bus.i_rom_ack = 1'b0;
      check("b2b_hold_done", 32'(bus.o_fetch_done), 32'h0);
      @(negedge clk);
      check("b2b_done", 32'(bus.o_fetch_done), 32'h1);
      if (i > 0) check("b2b_spacing", 32'(cyc - last), 32'd3);
      last = cyc;
      nxt = (i < 3) ? 8'(i + 1) : 8'h70;
      bus.i_Address_Instruction_Bus = nxt;
      addr_q.push_back(nxt);
      @(negedge clk);
      check("b2b_wait_done", 32'(bus.o_fetch_done), 32'h0);
    end
    bus.i_ready = 1'b0;

`ifdef IFETCH_TIMEOUT_EN
    // No ack: timeout after 15 WAIT cycles, retry at current address
    bus.i_Address_Instruction_Bus = 8'h55;
    addr_q.push_back(8'h55);
    for (int i = 1; i < 15; i++) begin
      @(negedge clk);
      check("to_wait_rd",  32'(bus.o_rom_rd), 32'h1);
      check("to_wait_err", 32'(bus.o_err),    32'h0);
    end
    @(negedge clk);
    check("to_err", 32'(bus.o_err),    32'h1);
    check("to_rd",  32'(bus.o_rom_rd), 32'h0);
    @(negedge clk);
    check("retry_rd",  32'(bus.o_rom_rd), 32'h1);
    check("err_stick", 32'(bus.o_err),    32'h1);
`else
    // No ack: read held indefinitely, never an error
    bus.i_Address_Instruction_Bus = 8'h55;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.o_rom_rd !== 1'b1 || bus.o_err !== 1'b0) begin
        check("noto_rd",  32'(bus.o_rom_rd), 32'h1);
        check("noto_err", 32'(bus.o_err),    32'h0);
      end
    end
    check("noto_rd_end",   32'(bus.o_rom_rd),   32'h1);
    check("noto_err_end",  32'(bus.o_err),      32'h0);
    check("noto_addr_end", 32'(bus.o_rom_addr), 32'h70);
`endif

    @(negedge clk);
    check("addr_q_drained",  32'(addr_q.size()),  32'd0);
    check("instr_q_drained", 32'(instr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
